// File: rtl/conv_kxk_chain.sv
// Transposed-form systolic KSIZE x KSIZE multiply-accumulate chain with serial weight load,
// valid/ready activation intake, fill tracking, synchronous clear and optional ReLU output.
module conv_kxk_chain #(
    parameter int KSIZE = 5,
    parameter int QW    = 8,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [QW-1:0] w_in,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic signed [QW-1:0] d_in,
    input  logic                 d_valid,
    output logic                 d_ready,
    input  logic                 z_en,
    input  logic                 relu_en,
    output logic                 loaded,
    output logic [DW-1:0]        ans_out,
    output logic                 ans_valid,
    output logic [1:0]           fsm_state
);

    localparam int N  = KSIZE * KSIZE;
    localparam int CW = $clog2(N + 1);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [LW-1:0]         load_cnt;
    logic [LW-1:0]         load_cnt_next;
    logic [CW-1:0]         fill;
    logic [CW-1:0]         fill_next;
    logic signed [QW-1:0]  weight [N];
    logic signed [DW-1:0]  psum   [N];
    logic signed [DW-1:0]  prod   [N];
    logic                  d_accept;
    logic                  reload;

    // Handshakes: a transfer happens on a cycle where valid & ready are both high.
    // Weights are always accepted; data only in RUN and only when no weight competes.
    assign w_ready   = 1'b1;
    assign d_ready   = (state == RUN) && !w_valid;
    assign d_accept  = d_valid && d_ready;
    assign reload    = (state == RUN) && w_valid;
    assign loaded    = (state == RUN);
    assign fsm_state = state;
    assign ans_out   = (relu_en && psum[N-1][DW-1]) ? '0 : psum[N-1];

    for (genvar k = 0; k < N; k++) begin : g_tap
        logic signed [2*QW-1:0] mul;
        assign mul     = d_in * weight[k];
        assign prod[k] = DW'(mul);
    end

    // load_cnt holds the number of weights taken so far in the current load.
    always_comb begin
        state_next    = state;
        load_cnt_next = load_cnt;
        case (state)
            EMPTY, RUN: begin
                if (w_valid) begin
                    if (N == 1) begin
                        state_next    = RUN;
                        load_cnt_next = '0;
                    end else begin
                        state_next    = LOAD;
                        load_cnt_next = LW'(1);
                    end
                end
            end
            LOAD: begin
                if (w_valid) begin
                    if (load_cnt == LW'(N - 1)) begin
                        state_next    = RUN;
                        load_cnt_next = '0;
                    end else begin
                        load_cnt_next = load_cnt + LW'(1);
                    end
                end
            end
            default: begin
                state_next    = EMPTY;
                load_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        fill_next = fill;
        if (z_en) begin
            fill_next = d_accept ? CW'(1) : '0;
        end else if (reload) begin
            fill_next = '0;
        end else if (d_accept && (fill != CW'(N))) begin
            fill_next = fill + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            load_cnt  <= '0;
            fill      <= '0;
            ans_valid <= 1'b0;
        end else begin
            state     <= state_next;
            load_cnt  <= load_cnt_next;
            fill      <= fill_next;
            ans_valid <= d_accept && (fill_next == CW'(N));
        end
    end

    // Newest weight enters the output end; the first-loaded one ends up at the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) weight[k] <= '0;
        end else if (w_valid) begin
            for (int k = 0; k < N - 1; k++) weight[k] <= weight[k+1];
            weight[N-1] <= w_in;
        end
    end

    // A clear drops old partial sums; a sample arriving with it starts a fresh window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) psum[k] <= '0;
        end else if (z_en || reload) begin
            for (int k = 0; k < N; k++) psum[k] <= (z_en && d_accept) ? prod[k] : '0;
        end else if (d_accept) begin
            psum[0] <= prod[0];
            for (int k = 1; k < N; k++) psum[k] <= psum[k-1] + prod[k];
        end
    end

endmodule

// File: tb/tb_conv_kxk_chain.sv
// Directed self-checking bench for conv_kxk_chain: a KSIZE=3 and a KSIZE=5 instance
// share one stimulus stream; each check compares against hand-computed values.
module tb_conv_kxk_chain;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic signed [7:0] w_in = '0;
    logic              w_valid = 1'b0;
    logic signed [7:0] d_in = '0;
    logic              d_valid = 1'b0;
    logic              z_en = 1'b0;
    logic              relu_en = 1'b0;

    logic        w_ready3, d_ready3, loaded3, ans_valid3;
    logic [31:0] ans_out3;
    logic [1:0]  st3;
    logic        w_ready5, d_ready5, loaded5, ans_valid5;
    logic [31:0] ans_out5;
    logic [1:0]  st5;

    int tests_run = 0;
    int tests_failed = 0;
    int valid_cnt = 0;
    logic signed [7:0] wv [25];

    always #5 clk = ~clk;

    conv_kxk_chain #(.KSIZE(3), .QW(8), .DW(32)) dut3 (
        .clk(clk), .rst(rst), .w_in(w_in), .w_valid(w_valid), .w_ready(w_ready3),
        .d_in(d_in), .d_valid(d_valid), .d_ready(d_ready3), .z_en(z_en), .relu_en(relu_en),
        .loaded(loaded3), .ans_out(ans_out3), .ans_valid(ans_valid3), .fsm_state(st3)
    );

    conv_kxk_chain #(.KSIZE(5), .QW(8), .DW(32)) dut5 (
        .clk(clk), .rst(rst), .w_in(w_in), .w_valid(w_valid), .w_ready(w_ready5),
        .d_in(d_in), .d_valid(d_valid), .d_ready(d_ready5), .z_en(z_en), .relu_en(relu_en),
        .loaded(loaded5), .ans_out(ans_out5), .ans_valid(ans_valid5), .fsm_state(st5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            w_in = wv[i];
            w_valid = 1'b1;
            tick();
        end
        w_valid = 1'b0;
    endtask

    task automatic send(input logic signed [7:0] x);
        d_in = x;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        if (ans_valid3) valid_cnt++;
    endtask

    initial begin
        // Reset state, with data offered that must be refused
        d_valid = 1'b1;
        #12;
        chk("rst_loaded", 32'(loaded3), 32'd0);
        chk("rst_ans_valid", 32'(ans_valid3), 32'd0);
        chk("rst_ans_out", ans_out3, 32'd0);
        chk("rst_d_ready", 32'(d_ready3), 32'd0);
        chk("rst_w_ready", 32'(w_ready3), 32'd1);
        chk("rst_state", 32'(st3), 32'd0);
        d_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Load W = 1..9 and stream ones
        for (int i = 0; i < 9; i++) wv[i] = 8'(i + 1);
        load_weights(0, 8);
        chk("load8_loaded", 32'(loaded3), 32'd0);
        chk("load8_state", 32'(st3), 32'd1);
        load_weights(8, 1);
        chk("load9_loaded", 32'(loaded3), 32'd1);
        chk("load9_state", 32'(st3), 32'd2);
        valid_cnt = 0;
        repeat (8) send(1);
        chk("ones_no_early_valid", 32'(valid_cnt), 32'd0);
        send(1);
        chk("ones_valid9", 32'(ans_valid3), 32'd1);
        chk("ones_sum9", ans_out3, 32'd45);
        send(1);
        chk("ones_valid10", 32'(ans_valid3), 32'd1);
        chk("ones_sum10", ans_out3, 32'd45);
        tick();
        chk("valid_pulse", 32'(ans_valid3), 32'd0);

        // Clear, then x = 1..9 with gaps
        z_en = 1'b1;
        tick();
        z_en = 1'b0;
        chk("zclr_out", ans_out3, 32'd0);
        valid_cnt = 0;
        for (int m = 1; m <= 4; m++) send(8'(m));
        chk("ramp_partial4", ans_out3, 32'd80);
        repeat (3) tick();
        chk("ramp_frozen", ans_out3, 32'd80);
        chk("ramp_gap_valid", 32'(ans_valid3), 32'd0);
        for (int m = 5; m <= 9; m++) begin
            send(8'(m));
            if (m < 9) repeat ($urandom_range(0, 2)) tick();
        end
        chk("ramp_valid", 32'(ans_valid3), 32'd1);
        chk("ramp_sum", ans_out3, 32'd285);
        chk("ramp_valid_count", 32'(valid_cnt), 32'd1);

        // Clear with a simultaneous accept after four samples of 2
        repeat (4) send(2);
        z_en = 1'b1;
        valid_cnt = 0;
        send(1);
        z_en = 1'b0;
        chk("zacc_first_valid", 32'(ans_valid3), 32'd0);
        repeat (7) send(1);
        chk("zacc_no_early_valid", 32'(valid_cnt), 32'd0);
        send(1);
        chk("zacc_valid", 32'(ans_valid3), 32'd1);
        chk("zacc_sum", ans_out3, 32'd45);

        // Weight and data together in RUN: weight wins, reload starts
        w_in = 8'sd1;
        w_valid = 1'b1;
        d_in = 8'sd5;
        d_valid = 1'b1;
        #1;
        chk("conflict_d_ready", 32'(d_ready3), 32'd0);
        tick();
        w_valid = 1'b0;
        d_valid = 1'b0;
        chk("reload_loaded", 32'(loaded3), 32'd0);
        chk("reload_state", 32'(st3), 32'd1);
        chk("reload_out", ans_out3, 32'd0);
        chk("reload_valid", 32'(ans_valid3), 32'd0);
        d_in = 8'sd100;
        d_valid = 1'b1;
        #1;
        chk("load_d_ready", 32'(d_ready3), 32'd0);
        tick();
        d_valid = 1'b0;
        for (int i = 0; i < 8; i++) wv[i] = 8'sd1;
        load_weights(0, 8);
        chk("reload_done", 32'(loaded3), 32'd1);
        valid_cnt = 0;
        for (int m = 1; m <= 8; m++) send(8'(m));
        chk("reload_no_early_valid", 32'(valid_cnt), 32'd0);
        send(9);
        chk("reload_valid9", 32'(ans_valid3), 32'd1);
        chk("reload_sum", ans_out3, 32'd45);

        // Asynchronous reset mid-load
        for (int i = 0; i < 9; i++) wv[i] = 8'(i + 1);
        load_weights(0, 4);
        #2 rst = 1'b0;
        #1;
        chk("rst_midload_state", 32'(st3), 32'd0);
        chk("rst_midload_loaded", 32'(loaded3), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        d_valid = 1'b1;
        d_in = 8'sd3;
        #1;
        chk("post_rst_d_ready", 32'(d_ready3), 32'd0);
        tick();
        d_valid = 1'b0;
        chk("post_rst_valid", 32'(ans_valid3), 32'd0);
        chk("post_rst_out", ans_out3, 32'd0);

        // Asynchronous reset mid-stream
        load_weights(0, 9);
        repeat (5) send(1);
        chk("stream5_partial", ans_out3, 32'd35);
        d_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_midstream_out", ans_out3, 32'd0);
        chk("rst_midstream_valid", 32'(ans_valid3), 32'd0);
        chk("rst_midstream_loaded", 32'(loaded3), 32'd0);
        chk("rst_midstream_d_ready", 32'(d_ready3), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        d_in = 8'sd1;
        tick();
        d_valid = 1'b0;
        chk("rst_ignored_data", 32'(ans_valid3), 32'd0);
        load_weights(0, 9);
        valid_cnt = 0;
        repeat (9) send(1);
        chk("after_rst_sum", ans_out3, 32'd45);
        chk("after_rst_valid_count", 32'(valid_cnt), 32'd1);

        // KSIZE=5: extreme negative operands, then ReLU
        rst = 1'b0;
        #3;
        rst = 1'b1;
        tick();
        for (int i = 0; i < 25; i++) wv[i] = -8'sd128;
        load_weights(0, 25);
        chk("k5_loaded", 32'(loaded5), 32'd1);
        repeat (24) send(-8'sd128);
        chk("k5_no_early_valid", 32'(ans_valid5), 32'd0);
        send(-8'sd128);
        chk("k5_valid", 32'(ans_valid5), 32'd1);
        chk("k5_min_sum", ans_out5, 32'd409600);
        for (int i = 0; i < 25; i++) wv[i] = -8'sd1;
        load_weights(0, 25);
        chk("k5_reloaded", 32'(loaded5), 32'd1);
        relu_en = 1'b1;
        repeat (25) send(1);
        chk("k5_relu_valid", 32'(ans_valid5), 32'd1);
        chk("k5_relu_on", ans_out5, 32'd0);
        relu_en = 1'b0;
        #1;
        chk("k5_relu_off", ans_out5, 32'(-25));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/conv_kxk_chain.md
Name: conv_kxk_chain

Overview:
- Parametrised successor of the fixed 25-tap convolution chain.
- Holds a transposed-form systolic chain of N = KSIZE*KSIZE multiply-accumulate taps. Weights are loaded serially through a counted load FSM.
- Broadcast activations are consumed under a valid/ready handshake. One dot-product result is produced per accepted sample once the chain is full.
- Sits between the activation line buffer and the output requantiser. Adds stall support, fill tracking, a reload path and optional ReLU, none of which the fixed chain has.

Parameters:
- KSIZE, 5, kernel edge; N = KSIZE*KSIZE taps, KSIZE in 1..7.
- QW, 8, signed weight/activation width (`QDATA_BUS_WIDTH).
- DW, 32, signed partial-sum/output width (`DATA_BUS_WIDTH), DW >= 2*QW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- w_in  in  QW  weight to load.
- w_valid  in  1  w_in valid.
- w_ready  out  1  weight accepted this cycle when w_valid & w_ready.
- d_in  in  QW  activation, broadcast to all taps.
- d_valid  in  1  d_in valid.
- d_ready  out  1  data accepted when d_valid & d_ready.
- z_en  in  1  synchronous clear of partial sums and fill count.
- relu_en  in  1  clamp negative outputs to 0; sampled combinationally at the output.
- loaded  out  1  full weight set present (state RUN).
- ans_out  out  DW  result.
- ans_valid  out  1  ans_out holds a complete window result, one-cycle pulse per result.

Behaviour:
- Taps k = 0..N-1. Tap 0 is the head (left input 0). Tap N-1 drives the output.
- FSM states: EMPTY, LOAD, RUN. Reset -> EMPTY.
- Weight shift: an accepted weight enters tap N-1, and all weights shift one tap toward tap 0.
  - After N loads, the first-loaded weight sits in tap 0, so load order is W[0] first.
- Load counter 0..N-1.
  - EMPTY + w_valid -> LOAD; this first weight counts as load #1.
  - In LOAD, the Nth accepted weight -> RUN and the counter returns to 0.
  - If N=1, EMPTY + w_valid goes directly to RUN.
- w_ready = 1 in every state.
- In RUN, w_valid starts a reload:
  - -> LOAD, first weight counted.
  - Partial sums cleared, fill count := 0, loaded drops next cycle.
- d_ready = (state==RUN) & ~w_valid. Combinational; a weight wins over data in the same cycle. d_valid outside RUN is ignored.
- On accept at time t: psum[k] <= psum[k-1] + sext(d_in*W[k]) for all k, with psum[-1] = 0.
  - Resulting output: ans_out(t) = sum over k of x(t-(N-1-k))*W[k]; W[N-1] multiplies the newest sample.
- Arithmetic:
  - Product is signed QW x QW -> 2QW, sign-extended to DW.
  - Adds wrap modulo 2^DW with no saturation.
- No accept: all psums and weights hold (stall).
- Fill counter:
  - Increments per accepted sample and saturates at N.
  - ans_valid <= accept & (fill_count_after_accept == N), i.e. asserted the cycle after the accept that produced the result (1-cycle latency).
  - ans_valid is otherwise 0.
- ans_out = (relu_en & psum[N-1][DW-1]) ? 0 : psum[N-1].
- z_en:
  - Clears all psums and fill := 0; weights and FSM are unaffected.
  - z_en with a simultaneous accept: clear takes priority for old data, and the sample is written as the first sample (psum[k] <= d_in*W[k], fill := 1).
  - z_en during LOAD: psums cleared, load continues.
- Reset (async, any time, including mid-load or mid-stream):
  - All weights, psums, counters := 0; state EMPTY.
  - loaded=0, ans_valid=0, ans_out=0, d_ready=0, w_ready=1.
- Reload mid-stream discards in-flight partial results; no ans_valid for them.

Test Plan:
- KSIZE=3; load W=1..9; stream 9 samples of 1 -> ans_valid exactly once, the cycle after the 9th accept, ans_out=45; the 10th sample of 1 -> ans_out=45 again.
- KSIZE=3, W=1..9; samples x=1..9 -> result = sum k=0..8 of x(k+1)*W[k] = 285. Insert random d_valid gaps -> same 285, ans_valid count unchanged, psums frozen during gaps.
- QW=8 with W all -128 and x all -128, KSIZE=5 -> 25*16384 = 409600. With W=-1, x=1, relu_en=1 -> ans_out=0; with relu_en=0 -> -25.
- Mid-stream z_en with a simultaneous accept after 4 samples -> the next ans_valid appears only after 8 further accepts (9 total from the clear sample) and excludes pre-clear data.
- w_valid and d_valid high together in RUN -> d_ready=0, state -> LOAD, loaded=0, no ans_valid until 9 new weights and 9 samples arrive.
- Assert rst low mid-load (after 4 weights) and mid-stream -> all outputs zero and state EMPTY immediately (asynchronous); data ignored until a full reload.
